// File: rtl/cic_pkg.sv
// Shared types, width defaults and the interpolation-factor decode for the CIC interpolator.
package cic_pkg;

  localparam int IN_W_DEF  = 16;
  localparam int N_DEF     = 3;
  localparam int ACC_W_DEF = 32;
  localparam int K_MAX     = 4;
  localparam int R_W       = 8;

  typedef enum logic {IDLE, EMIT} fsm_t;

  typedef struct packed {
    logic [2:0]     k;
    logic [R_W-1:0] r;
  } rate_t;

  // sel above K_MAX clamps to K_MAX, so R saturates at 16
  function automatic rate_t decode_rate(input logic [2:0] sel);
    rate_t d;
    d.k = (sel > 3'(K_MAX)) ? 3'(K_MAX) : sel;
    d.r = R_W'(1) << d.k;
    return d;
  endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One comb differencer y = x - x_z1; the delay loads only on an accepted sample.
// Zero latency through y; the delay register holds whenever load is low.
module cic_comb_stage #(
  parameter int W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clk_enable,
  input  logic                clear,
  input  logic                load,
  input  logic signed [W-1:0] x,
  output logic signed [W-1:0] y
);

  logic signed [W-1:0] x_z1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      x_z1 <= '0;
    else if (clk_enable) begin
      if (clear)
        x_z1 <= '0;
      else if (load)
        x_z1 <= x;
    end
  end

  assign y = x - x_z1;

endmodule

// File: rtl/cic_interp.sv
// N-stage CIC interpolator by R in {1,2,4,8,16}: first output 2 edges after accept, one input per R+1 cycles.
// out_ready low stalls the integrators with output held; CIC_INTERP_GAIN_COMP_EN divides out the R^(N-1) gain.
module cic_interp
  import cic_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int N     = N_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clk_enable,
  input  logic                    enable,
  input  logic [2:0]              interp_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  in_sample,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [IN_W-1:0]  out_sample,
  output logic signed [ACC_W-1:0] out_wide,
  output logic [R_W-1:0]          R_active
);

  fsm_t state_q, state_d;
  logic accept, advance, last_phase;

  rate_t                   rate;
  logic [2:0]              k_q;
  logic [R_W-1:0]          phase_q;
  logic signed [ACC_W-1:0] hold_q;
  logic signed [ACC_W-1:0] comb_x [N+1];
  logic signed [ACC_W-1:0] integ_q [N];
  logic signed [ACC_W-1:0] integ_d [N];
  logic signed [ACC_W-1:0] int_acc;
  logic signed [ACC_W-1:0] scaled;

  assign rate       = decode_rate(interp_sel);
  assign last_phase = (phase_q == ((R_W'(1) << k_q) - R_W'(1)));

  assign comb_x[0] = {{(ACC_W-IN_W){in_sample[IN_W-1]}}, in_sample};

  for (genvar g = 0; g < N; g++) begin : g_comb
    cic_comb_stage #(.W(ACC_W)) u_comb (
      .clk       (clk),
      .rst_n     (rst_n),
      .clk_enable(clk_enable),
      .clear     (!enable),
      .load      (accept),
      .x         (comb_x[g]),
      .y         (comb_x[g+1])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= IDLE;
    else if (clk_enable)
      state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    accept   = 1'b0;
    advance  = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = enable;
        accept   = enable && in_valid;
        if (accept)
          state_d = EMIT;
      end
      EMIT: begin
        advance = enable && (!out_valid || out_ready);
        if (advance && last_phase)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (!enable)
      state_d = IDLE;
  end

  // Zero-stuffed input cascades through post-update integrator values, so
  // the last stage reflects this advance with no extra pipeline delay.
  always_comb begin
    int_acc = (phase_q == '0) ? hold_q : '0;
    for (int i = 0; i < N; i++) begin
      int_acc    = integ_q[i] + int_acc;
      integ_d[i] = int_acc;
    end
  end

`ifdef CIC_INTERP_GAIN_COMP_EN
  localparam int SH_PER_K = N - 1;
  logic [7:0] shamt;
  assign shamt  = 8'(int'(k_q) * SH_PER_K);
  assign scaled = integ_d[N-1] >>> shamt;
`else
  assign scaled = integ_d[N-1];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q     <= '0;
      phase_q    <= '0;
      k_q        <= '0;
      R_active   <= R_W'(1);
      out_valid  <= 1'b0;
      out_sample <= '0;
      out_wide   <= '0;
      for (int i = 0; i < N; i++) integ_q[i] <= '0;
    end else if (clk_enable) begin
      if (!enable) begin
        hold_q    <= '0;
        phase_q   <= '0;
        out_valid <= 1'b0;
        for (int i = 0; i < N; i++) integ_q[i] <= '0;
      end else begin
        if (accept) begin
          hold_q   <= comb_x[N];
          k_q      <= rate.k;
          R_active <= rate.r;
          phase_q  <= '0;
        end
        if (advance) begin
          for (int i = 0; i < N; i++) integ_q[i] <= integ_d[i];
          out_wide   <= scaled;
          out_sample <= scaled[IN_W-1:0];
          out_valid  <= 1'b1;
          phase_q    <= phase_q + R_W'(1);
        end else if (out_valid && out_ready) begin
          out_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_cic_interp.sv
// Directed bench for cic_interp: impulse/DC responses, backpressure, rate latching, reset and soft-clear aborts.
module tb_cic_interp;

`ifdef CIC_INTERP_GAIN_COMP_EN
  localparam bit GC = 1'b1;
`else
  localparam bit GC = 1'b0;
`endif

  localparam logic signed [15:0] AMP2  = GC ? 16'sd4  : 16'sd1;
  localparam logic signed [15:0] AMP4  = GC ? 16'sd16 : 16'sd1;
  localparam int                 DC_EX = GC ? 1000    : 16000;

  logic               clk = 1'b0;
  logic               rst_n, clk_enable, enable, in_valid, in_ready, out_valid, out_ready;
  logic [2:0]         interp_sel;
  logic signed [15:0] in_sample, out_sample;
  logic signed [31:0] out_wide;
  logic [7:0]         R_active;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  logic signed [15:0] got_q[$];
  int                 acc_t[$];

  int exp2[10] = '{1, 3, 3, 1, 0, 0, 0, 0, 0, 0};
  int exp4[16] = '{1, 3, 6, 10, 12, 12, 10, 6, 3, 1, 0, 0, 0, 0, 0, 0};

  cic_interp dut (
    .clk(clk), .rst_n(rst_n), .clk_enable(clk_enable), .enable(enable),
    .interp_sel(interp_sel), .in_valid(in_valid), .in_ready(in_ready),
    .in_sample(in_sample), .out_valid(out_valid), .out_ready(out_ready),
    .out_sample(out_sample), .out_wide(out_wide), .R_active(R_active)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (out_valid && out_ready && clk_enable && rst_n) got_q.push_back(out_sample);
    if (in_valid && in_ready && clk_enable && rst_n) acc_t.push_back(cyc);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, $signed(got), $signed(exp));
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic signed [15:0] s);
    in_sample = s;
    in_valid  = 1'b1;
    @(negedge clk);
    for (int t = 0; t < 200 && !in_ready; t++) @(negedge clk);
    check("send_rdy", 32'(in_ready), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    @(negedge clk);
    for (int t = 0; t < 400 && !(in_ready && !out_valid); t++) @(negedge clk);
    check(tag, {30'b0, in_ready, out_valid}, 2);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_block();
    enable = 1'b0;
    tick(1);
    enable = 1'b1;
    got_q.delete();
    acc_t.delete();
  endtask

  initial begin
    rst_n = 1'b0; clk_enable = 1'b1; enable = 1'b1; in_valid = 1'b0;
    in_sample = '0; out_ready = 1'b1; interp_sel = 3'd1;
    #12;
    check("rst_vld", 32'(out_valid), 0);
    check("rst_wide", out_wide, 0);
    check("rst_smp", 32'(out_sample), 0);
    check("rst_ra", 32'(R_active), 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(1);

    // R=2 impulse, with first-output latency
    in_sample = AMP2; in_valid = 1'b1;
    tick(1);
    in_valid = 1'b0; in_sample = '0;
    check("lat_e1_vld", 32'(out_valid), 0);
    check("busy_rdy", 32'(in_ready), 0);
    check("ra_r2", 32'(R_active), 2);
    tick(1);
    check("lat_e2_vld", 32'(out_valid), 1);
    check("lat_e2_dat", 32'(out_sample), 1);
    for (int i = 0; i < 4; i++) send(16'sd0);
    wait_idle("drain_r2");
    check("imp2_cnt", got_q.size(), 10);
    for (int i = 0; i < 10; i++)
      if (i < got_q.size()) check($sformatf("imp2_%0d", i), 32'(got_q[i]), exp2[i]);

    // R=4 DC, accept spacing R+1
    clear_block();
    interp_sel = 3'd2;
    for (int i = 0; i < 8; i++) send(16'sd1000);
    wait_idle("drain_dc");
    check("dc_cnt", got_q.size(), 32);
    if (got_q.size() == 32) begin
      check("dc_7", 32'(got_q[7]), DC_EX);
      check("dc_31", 32'(got_q[31]), DC_EX);
    end
    check("dc_wide", out_wide, DC_EX);
    if (acc_t.size() == 8) begin
      check("acc_gap_a", acc_t[1] - acc_t[0], 5);
      check("acc_gap_b", acc_t[7] - acc_t[6], 5);
    end

    // R=4 impulse with 5-cycle stall mid-burst
    clear_block();
    send(AMP4);
    tick(2);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check("stall_vld", 32'(out_valid), 1);
      check("stall_dat", 32'(out_sample), 3);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) send(16'sd0);
    wait_idle("drain_stall");
    check("imp4_cnt", got_q.size(), 16);
    for (int i = 0; i < 16; i++)
      if (i < got_q.size()) check($sformatf("imp4_%0d", i), 32'(got_q[i]), exp4[i]);

    // sel=7 clamps to R=16; sel change and clk_enable pause mid-burst
    clear_block();
    interp_sel = 3'd7;
    send(16'sd1);
    check("ra_r16", 32'(R_active), 16);
    interp_sel = 3'd1;
    tick(2);
    clk_enable = 1'b0;
    tick(3);
    check("cke_ra", 32'(R_active), 16);
    clk_enable = 1'b1;
    wait_idle("drain_r16");
    check("r16_cnt", got_q.size(), 16);
    send(16'sd0);
    check("ra_new", 32'(R_active), 2);
    wait_idle("drain_r16b");
    check("r16b_cnt", got_q.size(), 18);

    // Reset at phase 2 of R=8
    clear_block();
    interp_sel = 3'd3;
    send(16'sd1);
    tick(2);
    rst_n = 1'b0;
    #1;
    got_q.delete();
    check("arst_vld", 32'(out_valid), 0);
    check("arst_ra", 32'(R_active), 1);
    check("arst_wide", out_wide, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    interp_sel = 3'd1;
    tick(20);
    check("arst_nout", got_q.size(), 0);
    send(AMP2);
    tick(1);
    check("arst_clean", 32'(out_sample), 1);
    wait_idle("drain_arst");

    // Soft clear mid-burst
    clear_block();
    interp_sel = 3'd2;
    send(16'sd1);
    tick(1);
    enable = 1'b0;
    tick(1);
    check("sclr_vld", 32'(out_valid), 0);
    check("sclr_rdy", 32'(in_ready), 0);
    got_q.delete();
    enable = 1'b1;
    #1;
    check("sclr_rdy_en", 32'(in_ready), 1);
    tick(10);
    check("sclr_nout", got_q.size(), 0);
    interp_sel = 3'd1;
    send(AMP2);
    tick(1);
    check("sclr_clean", 32'(out_sample), 1);
    wait_idle("drain_sclr");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got %0d cycles, expected completion", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cic_interp.md
CIC_INTERP -- requirements
Module: cic_interp

Interface
REQ-001 Parameter IN_W, default 16: input and output sample width, Q1.15.
REQ-002 Parameter N, default 3: number of comb stages and number of integrator stages.
REQ-003 Parameter ACC_W, default 32: internal two's-complement accumulator width.
REQ-004 clk  in  1  clock; all state SHALL update on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 clk_enable  in  1  global qualifier; when 0, all state SHALL hold.
REQ-007 enable  in  1  block enable; when 0, a synchronous soft-clear applies (REQ-021).
REQ-008 interp_sel  in  3  interpolation factor R = 1<<min(interp_sel,4), giving R in {1,2,4,8,16}.
REQ-009 in_valid / in_ready  in / out  1 / 1  input handshake; a sample is accepted on a cycle where both are 1 and clk_enable=1.
REQ-010 in_sample  in  IN_W  signed input sample.
REQ-011 out_valid / out_ready  out / in  1 / 1  output handshake; a sample transfers when both are 1 and clk_enable=1.
REQ-012 out_sample  out  IN_W  signed output, truncated and unsaturated.
REQ-013 out_wide  out  ACC_W  signed, scaled, full-width output.
REQ-014 R_active  out  8  R latched for the sample currently in progress.

Function
REQ-015 FSM states SHALL be IDLE and EMIT; in_ready SHALL equal 1 only in IDLE with enable=1.
REQ-016 On accept:
- in_sample is sign-extended to ACC_W and passed through the N comb stages (y = x - x_z1 per stage, delays updated).
- The comb result is registered into hold.
- R is latched into k_q / R_active.
- phase is cleared to 0 and the FSM moves to EMIT.
REQ-017 In EMIT, the integrators SHALL advance only when (!out_valid || out_ready).
- Integrator input = hold when phase==0, else 0 (zero-stuffing).
- The result from the last integrator (post-update) is scaled and registered to out_sample / out_wide, with out_valid <= 1.
- phase increments on each advance.
REQ-018 When the advance with phase==R-1 occurs, the FSM SHALL return to IDLE; with R=1, every accepted sample yields exactly one output.
REQ-019 out_valid SHALL drop to 0 on a transfer cycle that produces no new output, and SHALL hold its data stable while out_ready=0.
REQ-020 Latency and throughput:
- First output is valid 2 edges after the accept edge.
- Sustained throughput is one input per R+1 cycles when out_ready=1.
REQ-021 enable=0 (with clk_enable=1) SHALL clear comb delays, integrators, hold, phase, out_valid and the FSM (to IDLE) on the next edge.
REQ-022 All adds and subtracts SHALL be modular at ACC_W; wrap-around is legal and SHALL NOT be detected.
REQ-023 A change of interp_sel while in EMIT SHALL NOT affect the sample in progress.

Reset
REQ-024 rst_n=0 SHALL force: all registers to 0, FSM to IDLE, out_valid=0, out_sample=0, out_wide=0, R_active=1.
REQ-025 Reset asserted mid-EMIT SHALL abort the sample with no further output.

Configuration
REQ-026 Macro CIC_INTERP_GAIN_COMP_EN:
- Defined: output = int_N >>> (k*(N-1)), compensating the interpolator gain R^(N-1).
- Undefined: no shift is applied (full gain).
- out_sample is always the low IN_W bits of the scaled value.

Structure
REQ-027 Shared package cic_pkg SHALL hold:
- the R decode function (sel -> k, R), which clamps sel above 4 to 4;
- the fsm_t enum {IDLE, EMIT};
- default width constants.
REQ-028 Sub-module cic_comb_stage (one registered-delay differencer) SHALL be instantiated N times; the integrators stay inline.

Verification
REQ-029 R=2 (sel=1), gain compensation off: input impulse 1 followed by zeros -> out_sample sequence 1,3,3,1, then all 0.
REQ-030 R=2, gain compensation on: input impulse 4 followed by zeros -> 1,3,3,1, then 0.
REQ-031 R=4 (sel=2), gain compensation on: DC input 1000 -> steady-state output 1000 (16000 with compensation off); in_ready low for 4 cycles per accept.
REQ-032 out_ready held 0 for 5 cycles mid-EMIT -> out_sample/out_valid stable; no sample lost or duplicated; phase count correct.
REQ-033 sel=7 -> R_active=16, 16 outputs per input; sel changed mid-EMIT -> current burst keeps the old R.
REQ-034 rst_n pulsed at phase 2 of R=8, and separately enable=0 mid-EMIT -> out_valid=0 next cycle, integrators 0, in_ready=1 once enabled.
